// File: rtl/i2c_cmd_sequencer.sv
// Host-side command FIFO and transaction sequencer for i2c_controller.
// Issues one buffered command at a time, tracks controller busy, returns one response per command.
module i2c_cmd_sequencer #(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] TIMEOUT = 16'hFFFF,
  parameter int          GAP     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [6:0]               cmd_addr,
  input  logic [7:0]               cmd_reg,
  input  logic                     cmd_rw,
  input  logic [15:0]              cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [15:0]              rsp_data,
  output logic                     rsp_rw,
  output logic                     rsp_error,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     i2c_en,
  output logic [6:0]               i2c_peripheral_address,
  output logic [7:0]               i2c_target_register,
  output logic                     i2c_rw,
  output logic [15:0]              i2c_din,
  input  logic                     i2c_busy,
  input  logic [15:0]              i2c_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  logic [2:0]    state;
  logic [15:0]   timer;
  logic [GW-1:0] gap_cnt;

  logic          sync1;
  logic          sync2;
  logic          sync3;
  logic          busy_s;
  logic          busy_rise;
  logic          busy_fall;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign cmd_ready = (fifo_level != LW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == S_IDLE) && (fifo_level != '0) && !busy_s;
  assign head      = mem[rd_ptr];

  assign busy_s    = sync2;
  assign busy_rise = sync2 & ~sync3;
  assign busy_fall = ~sync2 & sync3;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {cmd_addr, cmd_reg, cmd_rw, cmd_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= i2c_busy;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // rsp_valid is set one cycle after RESP entry, so it rises the cycle after i2c_en falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= S_IDLE;
      timer                  <= '0;
      gap_cnt                <= '0;
      i2c_en                 <= 1'b0;
      i2c_peripheral_address <= '0;
      i2c_target_register    <= '0;
      i2c_rw                 <= 1'b0;
      i2c_din                <= '0;
      rsp_valid              <= 1'b0;
      rsp_data               <= '0;
      rsp_rw                 <= 1'b0;
      rsp_error              <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din} <= head;
            i2c_en <= 1'b1;
            timer  <= '0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (busy_rise) begin
            timer <= '0;
            state <= S_RUN;
          end else if (timer == TIMEOUT) begin
            i2c_en    <= 1'b0;
            rsp_error <= 1'b1;
            rsp_data  <= '0;
            rsp_rw    <= i2c_rw;
            state     <= S_RESP;
          end else if (timer != 16'hFFFF) begin
            timer <= timer + 1'b1;
          end
        end
        S_RUN: begin
          if (busy_fall) begin
            i2c_en    <= 1'b0;
            rsp_error <= 1'b0;
            rsp_data  <= i2c_rw ? 16'h0 : i2c_dout;
            rsp_rw    <= i2c_rw;
            state     <= S_RESP;
          end else if (timer == TIMEOUT) begin
            i2c_en    <= 1'b0;
            rsp_error <= 1'b1;
            rsp_data  <= '0;
            rsp_rw    <= i2c_rw;
            state     <= S_RESP;
          end else if (timer != 16'hFFFF) begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            gap_cnt   <= GW'(GAP);
            state     <= S_GAP;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        S_GAP: begin
          if (gap_cnt <= GW'(1))
            state <= S_IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed self-checking bench for i2c_cmd_sequencer with an inline controller busy model.
// Bench sits on the falling edge: inputs are driven and outputs sampled there.
module tb_i2c_cmd_sequencer;

  localparam int          TB_DEPTH   = 8;
  localparam logic [15:0] TB_TIMEOUT = 16'd250;
  localparam int          TB_GAP     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_reg;
  logic        cmd_rw;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_rw;
  logic        rsp_error;
  logic [3:0]  fifo_level;
  logic        i2c_en;
  logic [6:0]  i2c_peripheral_address;
  logic [7:0]  i2c_target_register;
  logic        i2c_rw;
  logic [15:0] i2c_din;
  logic        i2c_busy;
  logic [15:0] i2c_dout;

  int checks   = 0;
  int failures = 0;

  i2c_cmd_sequencer #(
    .DEPTH   (TB_DEPTH),
    .TIMEOUT (TB_TIMEOUT),
    .GAP     (TB_GAP)
  ) u_dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_addr               (cmd_addr),
    .cmd_reg                (cmd_reg),
    .cmd_rw                 (cmd_rw),
    .cmd_data               (cmd_data),
    .rsp_valid              (rsp_valid),
    .rsp_ready              (rsp_ready),
    .rsp_data               (rsp_data),
    .rsp_rw                 (rsp_rw),
    .rsp_error              (rsp_error),
    .fifo_level             (fifo_level),
    .i2c_en                 (i2c_en),
    .i2c_peripheral_address (i2c_peripheral_address),
    .i2c_target_register    (i2c_target_register),
    .i2c_rw                 (i2c_rw),
    .i2c_din                (i2c_din),
    .i2c_busy               (i2c_busy),
    .i2c_dout               (i2c_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic [7:0] r, input logic w,
                               input logic [15:0] d);
    cmd_addr  = a;
    cmd_reg   = r;
    cmd_rw    = w;
    cmd_data  = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitEn(input string tag);
    int n = 0;
    while (!i2c_en && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(i2c_en), 32'd1);
  endtask

  // Controller stand-in: busy rises shortly after en, drops after 'hold' cycles with dout valid.
  task automatic runBusy(input int hold, input logic [15:0] d);
    repeat (3) tick();
    i2c_busy = 1'b1;
    repeat (hold) tick();
    i2c_dout = d;
    i2c_busy = 1'b0;
  endtask

  task automatic takeResponse(input string tag, input logic [15:0] d, input logic w, input logic e);
    int n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'({rsp_valid, rsp_error, rsp_rw, rsp_data}), 32'({1'b1, e, w, d}));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput({tag, "_clr"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    logic en_seen;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_reg   = '0;
    cmd_rw    = 1'b0;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    i2c_busy  = 1'b0;
    i2c_dout  = '0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_ready_level", 32'({cmd_ready, fifo_level}), 32'({1'b1, 4'd0}));
    checkOutput("rst_rsp", 32'({rsp_valid, rsp_rw, rsp_error, rsp_data}), 32'd0);
    checkOutput("rst_en", 32'(i2c_en), 32'd0);
    checkOutput("rst_fields", {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din}, 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] write command");
    applyStimulus(7'h50, 8'h10, 1'b1, 16'hA55A);
    checkOutput("wr_lat1", 32'({i2c_en, fifo_level}), 32'({1'b0, 4'd1}));
    tick();
    checkOutput("wr_en_lat2", 32'(i2c_en), 32'd1);
    checkOutput("wr_fields", {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din},
                {7'h50, 8'h10, 1'b1, 16'hA55A});
    runBusy(200, 16'h1234);
    takeResponse("wr_rsp", 16'h0000, 1'b1, 1'b0);

    $display("[TB] read command");
    applyStimulus(7'h51, 8'h22, 1'b0, 16'h0000);
    waitEn("rd_en");
    checkOutput("rd_fields", {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din},
                {7'h51, 8'h22, 1'b0, 16'h0000});
    runBusy(40, 16'hBEEF);
    tick();
    tick();
    checkOutput("rd_en_hold", 32'(i2c_en), 32'd1);
    tick();
    checkOutput("rd_en_fall", 32'({i2c_en, rsp_valid}), 32'd0);
    tick();
    checkOutput("rd_valid_rise", 32'(rsp_valid), 32'd1);
    takeResponse("rd_rsp", 16'hBEEF, 1'b0, 1'b0);

    $display("[TB] full fifo with wrap");
    i2c_busy = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 8; i++)
      applyStimulus(7'(7'h20 + i), 8'(8'h80 + i), 1'b0, 16'(16'h1000 + i));
    checkOutput("full_level", 32'({cmd_ready, fifo_level}), 32'({1'b0, 4'd8}));
    applyStimulus(7'h7F, 8'hFF, 1'b0, 16'hFFFF);
    checkOutput("full_refused", 32'(fifo_level), 32'd8);
    cmd_valid = 1'b1;
    i2c_busy  = 1'b0;
    n = 0;
    while (fifo_level == 4'd8 && n < 10) begin
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    checkOutput("full_pushpop", 32'({cmd_ready, fifo_level}), 32'({1'b1, 4'd7}));
    for (int i = 0; i < 8; i++) begin
      waitEn("drain_en");
      checkOutput("drain_order", {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din},
                  {7'(7'h20 + i), 8'(8'h80 + i), 1'b0, 16'(16'h1000 + i)});
      runBusy(20, 16'(16'hD000 + i));
      takeResponse("drain_rsp", 16'(16'hD000 + i), 1'b0, 1'b0);
    end
    checkOutput("drain_empty", 32'(fifo_level), 32'd0);

    $display("[TB] response backpressure");
    for (int i = 0; i < 3; i++)
      applyStimulus(7'(7'h30 + i), 8'(8'h40 + i), 1'b0, 16'h0000);
    waitEn("bp_en");
    runBusy(10, 16'hC0DE);
    n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    for (int i = 0; i < 100; i++) begin
      checkOutput("bp_hold",
                  32'({rsp_valid, rsp_data, rsp_rw, rsp_error, i2c_en, fifo_level}),
                  32'({1'b1, 16'hC0DE, 1'b0, 1'b0, 1'b0, 4'd2}));
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n = 1;
    while (!i2c_en && n < 20) begin
      tick();
      n++;
    end
    checkOutput("bp_gap", 32'(n), 32'(TB_GAP + 2));
    checkOutput("bp_next", {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din},
                {7'h31, 8'h41, 1'b0, 16'h0000});
    runBusy(10, 16'h0101);
    takeResponse("bp_rsp1", 16'h0101, 1'b0, 1'b0);
    waitEn("bp_en2");
    runBusy(10, 16'h0202);
    takeResponse("bp_rsp2", 16'h0202, 1'b0, 1'b0);

    $display("[TB] timeout waiting for busy rise");
    applyStimulus(7'h11, 8'h01, 1'b1, 16'h5555);
    waitEn("to_iss_en");
    n = 0;
    while (i2c_en && n < 400) begin
      tick();
      n++;
    end
    checkOutput("to_iss_cycles", 32'(n), 32'(TB_TIMEOUT) + 32'd1);
    takeResponse("to_iss_rsp", 16'h0000, 1'b1, 1'b1);

    $display("[TB] timeout waiting for busy fall");
    i2c_dout = 16'h7777;
    applyStimulus(7'h12, 8'h02, 1'b0, 16'h0000);
    waitEn("to_run_en");
    tick();
    i2c_busy = 1'b1;
    n = 0;
    while (i2c_en && n < 400) begin
      tick();
      n++;
    end
    checkOutput("to_run_cycles", 32'(n), 32'(TB_TIMEOUT) + 32'd4);
    takeResponse("to_run_rsp", 16'h0000, 1'b0, 1'b1);

    $display("[TB] reset during transfer");
    i2c_busy = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++)
      applyStimulus(7'(7'h60 + i), 8'(8'h90 + i), 1'b0, 16'h0000);
    waitEn("rst_run_en");
    tick();
    i2c_busy = 1'b1;
    repeat (5) tick();
    checkOutput("rst_pre_level", 32'(fifo_level), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_flush", 32'({fifo_level, i2c_en, rsp_valid, cmd_ready}),
                32'({4'd0, 1'b0, 1'b0, 1'b1}));
    repeat (4) tick();
    applyStimulus(7'h6A, 8'hAA, 1'b0, 16'h0000);
    en_seen = 1'b0;
    repeat (30) begin
      tick();
      en_seen = en_seen | i2c_en;
    end
    checkOutput("rst_hold_noissue", 32'({en_seen, fifo_level}), 32'({1'b0, 4'd1}));
    i2c_busy = 1'b0;
    tick();
    tick();
    checkOutput("rst_issue_early", 32'(i2c_en), 32'd0);
    tick();
    checkOutput("rst_issue", 32'(i2c_en), 32'd1);
    checkOutput("rst_issue_fields", {i2c_peripheral_address, i2c_target_register, i2c_rw, i2c_din},
                {7'h6A, 8'hAA, 1'b0, 16'h0000});
    runBusy(10, 16'hABCD);
    takeResponse("rst_rsp", 16'hABCD, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
